vfu_wb_arbiter: RTL and testbench



---
 rtl/vfu_wb_arbiter.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_vfu_wb_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vfu_wb_arbiter.sv
// ---------------------------------------------------------------------------
// vfu_wb_arbiter
//
// Per-lane write-back stage shared by the vector functional units. Each of
// the NrFUs result channels is buffered in its own QueueDepth-entry FIFO. A
// round-robin arbiter moves the FIFO heads onto the single VRF write port.
// The block also folds the per-FU saturation pulses into one sticky vxsat
// flag.
//
// Once a request has been presented and refused, the arbiter locks onto that
// channel. The request and its payload then stay stable until the VRF
// grants it. Every output is derived from registered state only. There is
// no combinational path from fu_req_i or vrf_gnt_i to any output.
//
// Optional feature macro: ARA_VFU_WB_STATS_EN
//   defined   -> per-channel 32-bit saturating stall counters are built
//   undefined -> stall_cnt_o is tied to zero (the port is always present)
//
// Ports
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   fu_req_i     per channel: a result is offered
//   fu_id_i      per channel: instruction ID of the offered result
//   fu_addr_i    per channel: VRF address of the offered result
//   fu_wdata_i   per channel: write data of the offered result
//   fu_be_i      per channel: byte enables of the offered result
//   fu_gnt_o     per channel: result accepted this cycle (FIFO not full)
//   fu_empty_o   per channel: FIFO empty
//   vrf_req_o    VRF write request
//   vrf_id_o     instruction ID of the selected head entry
//   vrf_addr_o   VRF address of the selected head entry
//   vrf_wdata_o  write data of the selected head entry
//   vrf_be_o     byte enables of the selected head entry
//   vrf_gnt_i    VRF accepted the current request
//   vxsat_i      per-FU saturation pulse
//   vxsat_clr_i  clear the sticky saturation flag
//   vxsat_o      registered sticky saturation flag
//   stall_cnt_o  per-channel count of cycles offered while the FIFO was full
// ---------------------------------------------------------------------------
module vfu_wb_arbiter #(
  parameter int unsigned NrFUs      = 2,
  parameter int unsigned QueueDepth = 2,
  parameter type         vaddr_t    = logic,
  parameter type         vid_t      = logic [2:0],
  parameter type         elen_t     = logic [63:0],
  parameter int unsigned DataWidth  = $bits(elen_t),
  parameter type         strb_t     = logic [DataWidth/8-1:0]
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic   [NrFUs-1:0]        fu_req_i,
  input  vid_t   [NrFUs-1:0]        fu_id_i,
  input  vaddr_t [NrFUs-1:0]        fu_addr_i,
  input  elen_t  [NrFUs-1:0]        fu_wdata_i,
  input  strb_t  [NrFUs-1:0]        fu_be_i,
  output logic   [NrFUs-1:0]        fu_gnt_o,
  output logic   [NrFUs-1:0]        fu_empty_o,
  output logic                      vrf_req_o,
  output vid_t                      vrf_id_o,
  output vaddr_t                    vrf_addr_o,
  output elen_t                     vrf_wdata_o,
  output strb_t                     vrf_be_o,
  input  logic                      vrf_gnt_i,
  input  logic   [NrFUs-1:0]        vxsat_i,
  input  logic                      vxsat_clr_i,
  output logic                      vxsat_o,
  output logic   [NrFUs-1:0][31:0]  stall_cnt_o
);

  // -------------------------------------------------------------------------
  // Widths and types
  // -------------------------------------------------------------------------
  localparam int unsigned PtrW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int unsigned CntW = $clog2(QueueDepth + 1);
  localparam int unsigned SelW = (NrFUs > 1) ? $clog2(NrFUs) : 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;
  typedef logic [SelW-1:0] sel_t;

  typedef struct packed {
    vid_t   id;
    vaddr_t addr;
    elen_t  wdata;
    strb_t  be;
  } entry_t;

  // Pointers wrap with an explicit compare. A non-power-of-two depth
  // therefore never indexes past the last entry.
  function automatic ptr_t nextPtr(input ptr_t p);
    if (p == ptr_t'(QueueDepth - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  entry_t                 memQ [NrFUs][QueueDepth];
  ptr_t   [NrFUs-1:0]     wrPtr_q, wrPtr_d;
  ptr_t   [NrFUs-1:0]     rdPtr_q, rdPtr_d;
  cnt_t   [NrFUs-1:0]     cnt_q,   cnt_d;
  sel_t                   rr_q,      rr_d;
  logic                   lock_q,    lock_d;
  sel_t                   lockSel_q, lockSel_d;
  logic                   vxsat_q,   vxsat_d;

  logic   [NrFUs-1:0]     full;
  logic   [NrFUs-1:0]     empty;
  logic   [NrFUs-1:0]     push;
  logic   [NrFUs-1:0]     pop;
  sel_t                   sel;
  logic                   found;
  int unsigned            scanIdx;
  logic                   vrfReq;
  logic                   doPop;
  entry_t                 headEntry;

  // FIFO occupancy flags come straight from the registered counters. This
  // keeps fu_gnt_o free of any path from the request or VRF grant inputs.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int i = 0; i < int'(NrFUs); i++) begin
      full[i]  = (cnt_q[i] == cnt_t'(QueueDepth));
      empty[i] = (cnt_q[i] == '0);
    end
  end

  assign fu_gnt_o   = ~full;
  assign fu_empty_o = empty;
  assign push       = fu_req_i & ~full;

  // Channel selection. A held lock pins the refused channel. Otherwise the
  // scan starts at rr_q and takes the first non-empty channel, wrapping
  // modulo NrFUs.
  always_comb begin
    sel     = lockSel_q;
    found   = 1'b0;
    scanIdx = 0;
    if (!lock_q) begin
      sel = '0;
      for (int k = 0; k < int'(NrFUs); k++) begin
        scanIdx = int'(rr_q) + k;
        if (scanIdx >= NrFUs) begin
          scanIdx = scanIdx - NrFUs;
        end
        if (!found && !empty[sel_t'(scanIdx)]) begin
          sel   = sel_t'(scanIdx);
          found = 1'b1;
        end
      end
    end
  end

  assign vrfReq    = (|(~empty)) | lock_q;
  assign doPop     = vrfReq & vrf_gnt_i;
  assign headEntry = memQ[sel][rdPtr_q[sel]];

  // The head entry is gated with the request so that the payload reads as
  // zero whenever nothing is being offered, including straight after reset.
  always_comb begin
    vrf_req_o   = vrfReq;
    vrf_id_o    = '0;
    vrf_addr_o  = '0;
    vrf_wdata_o = '0;
    vrf_be_o    = '0;
    if (vrfReq) begin
      vrf_id_o    = headEntry.id;
      vrf_addr_o  = headEntry.addr;
      vrf_wdata_o = headEntry.wdata;
      vrf_be_o    = headEntry.be;
    end
  end

  // Pop only the selected channel, and only when the VRF grants a live
  // request. The empty guard means a count can never go below zero.
  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(NrFUs); i++) begin
      pop[i] = doPop && (sel == sel_t'(i)) && !empty[i];
    end
  end

  // FIFO pointer and occupancy next state. A push and a pop on the same
  // channel cancel out in the count.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < int'(NrFUs); i++) begin
      if (push[i]) begin
        wrPtr_d[i] = nextPtr(wrPtr_q[i]);
      end
      if (pop[i]) begin
        rdPtr_d[i] = nextPtr(rdPtr_q[i]);
      end
      if (push[i] && !pop[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (pop[i] && !push[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // Arbitration next state. A refused request locks the current choice. A
  // grant releases the lock and moves the round-robin start to the channel
  // after the one just served. A grant with no request is ignored.
  always_comb begin
    rr_d      = rr_q;
    lock_d    = lock_q;
    lockSel_d = lockSel_q;
    if (vrfReq && !vrf_gnt_i) begin
      lock_d    = 1'b1;
      lockSel_d = sel;
    end else if (doPop) begin
      lock_d = 1'b0;
      rr_d   = (sel == sel_t'(NrFUs - 1)) ? '0 : sel + 1'b1;
    end
  end

  // Sticky saturation. A new pulse wins over a clear in the same cycle.
  always_comb begin
    vxsat_d = (vxsat_q & ~vxsat_clr_i) | (|vxsat_i);
  end

  assign vxsat_o = vxsat_q;

  // Control state registers with synchronous active-low reset. Reset
  // empties every FIFO, which also discards the stored payloads.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      cnt_q     <= '0;
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lockSel_q <= '0;
      vxsat_q   <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lockSel_q <= lockSel_d;
      vxsat_q   <= vxsat_d;
    end
  end

  // FIFO storage is not reset. An entry is only ever read after a push has
  // written it, and the payload outputs are gated while no request is live.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(NrFUs); i++) begin
      if (push[i]) begin
        memQ[i][wrPtr_q[i]] <= '{id:    fu_id_i[i],
                                 addr:  fu_addr_i[i],
                                 wdata: fu_wdata_i[i],
                                 be:    fu_be_i[i]};
      end
    end
  end

`ifdef ARA_VFU_WB_STATS_EN
  logic [NrFUs-1:0][31:0] stallCnt_q, stallCnt_d;

  // A stall is a cycle in which a channel offers a result while its FIFO is
  // full. The counters stop at all-ones instead of wrapping.
  always_comb begin
    stallCnt_d = stallCnt_q;
    for (int i = 0; i < int'(NrFUs); i++) begin
      if (fu_req_i[i] && full[i] && (stallCnt_q[i] != 32'hFFFF_FFFF)) begin
        stallCnt_d[i] = stallCnt_q[i] + 32'd1;
      end
    end
  end

  // Stall counters are cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign stall_cnt_o = stallCnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vfu_wb_arbiter.sv
module tb_vfu_wb_arbiter;

  typedef logic [7:0]  addr_t;
  typedef logic [2:0]  id_t;
  typedef logic [63:0] data_t;

  logic                   clk;
  logic                   rstN;
  logic [1:0]             fuReq;
  logic [1:0][2:0]        fuId;
  logic [1:0][7:0]        fuAddr;
  logic [1:0][63:0]       fuWdata;
  logic [1:0][7:0]        fuBe;
  logic [1:0]             fuGnt;
  logic [1:0]             fuEmpty;
  logic                   vrfReq;
  logic [2:0]             vrfId;
  logic [7:0]             vrfAddr;
  logic [63:0]            vrfWdata;
  logic [7:0]             vrfBe;
  logic                   vrfGnt;
  logic [1:0]             vxsatIn;
  logic                   vxsatClr;
  logic                   vxsatOut;
  logic [1:0][31:0]       stallCnt;

  int total = 0;
  int bad   = 0;

`ifdef ARA_VFU_WB_STATS_EN
  localparam logic [31:0] BpStallExp = 32'd3;
`else
  localparam logic [31:0] BpStallExp = 32'd0;
`endif

  vfu_wb_arbiter #(
    .NrFUs      (2),
    .QueueDepth (2),
    .vaddr_t    (addr_t),
    .vid_t      (id_t),
    .elen_t     (data_t)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .fu_req_i    (fuReq),
    .fu_id_i     (fuId),
    .fu_addr_i   (fuAddr),
    .fu_wdata_i  (fuWdata),
    .fu_be_i     (fuBe),
    .fu_gnt_o    (fuGnt),
    .fu_empty_o  (fuEmpty),
    .vrf_req_o   (vrfReq),
    .vrf_id_o    (vrfId),
    .vrf_addr_o  (vrfAddr),
    .vrf_wdata_o (vrfWdata),
    .vrf_be_o    (vrfBe),
    .vrf_gnt_i   (vrfGnt),
    .vxsat_i     (vxsatIn),
    .vxsat_clr_i (vxsatClr),
    .vxsat_o     (vxsatOut),
    .stall_cnt_o (stallCnt)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One table row gives the inputs driven in a cycle. It also gives the
  // outputs expected during that same cycle, which depend only on the rows
  // before it.
  typedef struct {
    logic [1:0] req;
    logic [7:0] a0;
    logic [7:0] a1;
    logic       vg;
    logic [1:0] vx;
    logic       clr;
    logic       rst;
    logic       eReq;
    logic [7:0] eAddr;
    logic [1:0] eGnt;
    logic [1:0] eEmpty;
    logic       eVx;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] req, input logic [7:0] a0,
                              input logic [7:0] a1, input logic vg,
                              input logic [1:0] vx, input logic clr,
                              input logic rst, input logic eReq,
                              input logic [7:0] eAddr, input logic [1:0] eGnt,
                              input logic [1:0] eEmpty, input logic eVx);
    vec_t v;
    v.req = req; v.a0 = a0; v.a1 = a1; v.vg = vg; v.vx = vx; v.clr = clr;
    v.rst = rst; v.eReq = eReq; v.eAddr = eAddr; v.eGnt = eGnt;
    v.eEmpty = eEmpty; v.eVx = eVx;
    return v;
  endfunction

  // Drive every DUT input. Each channel's payload is derived from its
  // address, so a single byte identifies the whole entry.
  task automatic applyStimulus(input logic [1:0] req, input logic [7:0] a0,
                               input logic [7:0] a1, input logic vg,
                               input logic [1:0] vx, input logic clr,
                               input logic rst);
    fuReq      = req;
    fuAddr[0]  = a0;
    fuAddr[1]  = a1;
    fuId[0]    = a0[2:0];
    fuId[1]    = a1[2:0];
    fuWdata[0] = {8{a0}};
    fuWdata[1] = {8{a1}};
    fuBe[0]    = a0;
    fuBe[1]    = a1;
    vrfGnt     = vg;
    vxsatIn    = vx;
    vxsatClr   = clr;
    rstN       = ~rst;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Check the request and the full payload that an entry with address
  // eAddr carries. When no request is expected, the payload must be zero.
  task automatic checkVrf(input string tag, input logic eReq,
                          input logic [7:0] eAddr);
    logic [7:0] a;
    a = eReq ? eAddr : 8'h00;
    checkOutput({tag, "_req"},   vrfReq,   eReq);
    checkOutput({tag, "_addr"},  vrfAddr,  a);
    checkOutput({tag, "_id"},    vrfId,    a[2:0]);
    checkOutput({tag, "_wdata"}, vrfWdata, {8{a}});
    checkOutput({tag, "_be"},    vrfBe,    a);
  endtask

  initial begin
    // Single channel push, then reset, then a round-robin burst, then vxsat.
    vecs.push_back(mk(2'b01, 8'h10, 8'h00, 1, 2'b00, 0, 0, 0, 8'h00, 2'b11, 2'b11, 0));
    vecs.push_back(mk(2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 1, 8'h10, 2'b11, 2'b10, 0));
    vecs.push_back(mk(2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 0, 8'h00, 2'b11, 2'b11, 0));
    vecs.push_back(mk(2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 1, 0, 8'h00, 2'b11, 2'b11, 0));
    vecs.push_back(mk(2'b11, 8'h20, 8'h30, 1, 2'b00, 0, 0, 0, 8'h00, 2'b11, 2'b11, 0));
    vecs.push_back(mk(2'b11, 8'h21, 8'h31, 1, 2'b00, 0, 0, 1, 8'h20, 2'b11, 2'b00, 0));
    vecs.push_back(mk(2'b11, 8'h22, 8'h32, 1, 2'b00, 0, 0, 1, 8'h30, 2'b01, 2'b00, 0));
    vecs.push_back(mk(2'b10, 8'h00, 8'h32, 1, 2'b00, 0, 0, 1, 8'h21, 2'b10, 2'b00, 0));
    vecs.push_back(mk(2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 1, 8'h31, 2'b01, 2'b00, 0));
    vecs.push_back(mk(2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 1, 8'h22, 2'b11, 2'b00, 0));
    vecs.push_back(mk(2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 1, 8'h32, 2'b11, 2'b01, 0));
    vecs.push_back(mk(2'b00, 8'h00, 8'h00, 1, 2'b10, 0, 0, 0, 8'h00, 2'b11, 2'b11, 0));
    vecs.push_back(mk(2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 0, 8'h00, 2'b11, 2'b11, 1));
    vecs.push_back(mk(2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 0, 0, 8'h00, 2'b11, 2'b11, 1));
    vecs.push_back(mk(2'b00, 8'h00, 8'h00, 1, 2'b01, 1, 0, 0, 8'h00, 2'b11, 2'b11, 0));
    vecs.push_back(mk(2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 0, 8'h00, 2'b11, 2'b11, 1));
    vecs.push_back(mk(2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 0, 0, 8'h00, 2'b11, 2'b11, 1));
    vecs.push_back(mk(2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 0, 8'h00, 2'b11, 2'b11, 0));

    applyStimulus(2'b00, 8'h00, 8'h00, 0, 2'b00, 0, 1);
    repeat (2) @(posedge clk);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      checkVrf($sformatf("row%0d", k), vecs[k].eReq, vecs[k].eAddr);
      checkOutput($sformatf("row%0d_gnt", k),   fuGnt,    vecs[k].eGnt);
      checkOutput($sformatf("row%0d_empty", k), fuEmpty,  vecs[k].eEmpty);
      checkOutput($sformatf("row%0d_vxsat", k), vxsatOut, vecs[k].eVx);
      applyStimulus(vecs[k].req, vecs[k].a0, vecs[k].a1, vecs[k].vg,
                    vecs[k].vx, vecs[k].clr, vecs[k].rst);
    end

    // Backpressure: channel 1 pushes continuously while the VRF refuses for
    // five cycles.
    @(negedge clk);
    checkOutput("bp_gnt_accept1", fuGnt[1], 1'b1);
    applyStimulus(2'b10, 8'h00, 8'h40, 0, 2'b00, 0, 0);
    @(negedge clk);
    checkOutput("bp_gnt_accept2", fuGnt[1], 1'b1);
    checkVrf("bp_first", 1'b1, 8'h40);
    applyStimulus(2'b10, 8'h00, 8'h41, 0, 2'b00, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_gnt_full%0d", c), fuGnt[1], 1'b0);
      checkVrf($sformatf("bp_hold%0d", c), 1'b1, 8'h40);
      applyStimulus(2'b10, 8'h00, 8'h42, 0, 2'b00, 0, 0);
    end
    @(negedge clk);
    checkOutput("bp_gnt_full3", fuGnt[1], 1'b0);
    checkVrf("bp_hold3", 1'b1, 8'h40);
    checkOutput("bp_stall_cnt1", stallCnt[1], BpStallExp);
    checkOutput("bp_stall_cnt0", stallCnt[0], 32'd0);
    applyStimulus(2'b10, 8'h00, 8'h42, 1, 2'b00, 0, 0);
    @(negedge clk);
    checkVrf("bp_second", 1'b1, 8'h41);
    checkOutput("bp_gnt_reopen", fuGnt[1], 1'b1);
    applyStimulus(2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0);
    @(negedge clk);
    checkVrf("bp_drained", 1'b0, 8'h00);

    // Lock: move the round-robin start to channel 1 first, then let
    // channel 0 be refused while channel 1 fills in behind it.
    applyStimulus(2'b01, 8'h4F, 8'h00, 1, 2'b00, 0, 0);
    @(negedge clk);
    applyStimulus(2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0);
    @(negedge clk);
    checkVrf("lk_idle", 1'b0, 8'h00);
    applyStimulus(2'b01, 8'h50, 8'h00, 0, 2'b00, 0, 0);
    @(negedge clk);
    checkVrf("lk_ch0_first", 1'b1, 8'h50);
    applyStimulus(2'b10, 8'h00, 8'h60, 0, 2'b00, 0, 0);
    @(negedge clk);
    checkVrf("lk_ch0_held", 1'b1, 8'h50);
    checkOutput("lk_empty", fuEmpty, 2'b00);
    applyStimulus(2'b00, 8'h00, 8'h00, 0, 2'b00, 0, 0);
    @(negedge clk);
    checkVrf("lk_ch0_held2", 1'b1, 8'h50);
    applyStimulus(2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0);
    @(negedge clk);
    checkVrf("lk_ch1_next", 1'b1, 8'h60);
    applyStimulus(2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0);
    @(negedge clk);
    checkVrf("lk_drained", 1'b0, 8'h00);

    // Reset while both FIFOs are full and the flag is set.
    applyStimulus(2'b11, 8'h70, 8'h80, 0, 2'b00, 0, 0);
    @(negedge clk);
    checkOutput("rs_gnt_open", fuGnt, 2'b11);
    applyStimulus(2'b11, 8'h71, 8'h81, 0, 2'b01, 0, 0);
    @(negedge clk);
    checkOutput("rs_gnt_full", fuGnt, 2'b00);
    checkOutput("rs_empty_full", fuEmpty, 2'b00);
    checkOutput("rs_vxsat_set", vxsatOut, 1'b1);
    checkVrf("rs_before", 1'b1, 8'h70);
    applyStimulus(2'b11, 8'h72, 8'h82, 0, 2'b00, 0, 1);
    @(negedge clk);
    checkVrf("rs_after", 1'b0, 8'h00);
    checkOutput("rs_gnt", fuGnt, 2'b11);
    checkOutput("rs_empty", fuEmpty, 2'b11);
    checkOutput("rs_vxsat", vxsatOut, 1'b0);
    checkOutput("rs_stall", stallCnt, 64'd0);
    applyStimulus(2'b00, 8'h00, 8'h00, 0, 2'b00, 0, 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
